// File: rtl/mul_pipe_unit.sv
// Fully pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU) with a fixed issue-to-result latency of STAGES cycles.
// Define MUL_HAZARD_EN to add the pending_o mask of in-flight destination registers.
module mul_pipe_unit #(
    parameter int XLEN   = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4,
    parameter int REGS   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [1:0]       op_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [4:0]       rd_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [XLEN-1:0]  result_o,
    output logic [4:0]       rd_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
`ifdef MUL_HAZARD_EN
    ,
    output logic [REGS-1:0]  pending_o
`endif
);
    localparam logic [1:0] OP_MUL   = 2'd0;
    localparam logic [1:0] OP_MULH  = 2'd1;
    localparam logic [1:0] OP_MULHU = 2'd3;
    localparam int         LAST     = STAGES - 1;

    // One extra bit per operand turns all four variants into a single signed multiply.
    function automatic logic [XLEN:0] ext_a(input logic [XLEN-1:0] v, input logic [1:0] op);
        return {(op != OP_MULHU) & v[XLEN-1], v};
    endfunction

    function automatic logic [XLEN:0] ext_b(input logic [XLEN-1:0] v, input logic [1:0] op);
        return {((op == OP_MUL) || (op == OP_MULH)) & v[XLEN-1], v};
    endfunction

    function automatic logic [XLEN-1:0] mul_sel(input logic [XLEN:0] a, input logic [XLEN:0] b,
                                                input logic [1:0] op);
        logic [2*XLEN-1:0] p;
        p = {{(XLEN-1){a[XLEN]}}, a} * {{(XLEN-1){b[XLEN]}}, b};
        return (op == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    logic [STAGES-1:0] vld_q, vld_d;
    logic [1:0]        op_q  [STAGES];
    logic [1:0]        op_d  [STAGES];
    logic [4:0]        rd_q  [STAGES];
    logic [4:0]        rd_d  [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];
    logic [XLEN-1:0]   res_q [STAGES];
    logic [XLEN-1:0]   res_d [STAGES];
    logic [XLEN:0]     opa_d, opb_d;

    assign opa_d = ext_a(a_i, op_i);
    assign opb_d = ext_b(b_i, op_i);

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_slot
        if (gi == 0) begin : g_head
            assign vld_d[gi] = valid_i;
            assign op_d[gi]  = op_i;
            assign rd_d[gi]  = rd_i;
            assign tag_d[gi] = tag_i;
        end else begin : g_body
            assign vld_d[gi] = vld_q[gi-1];
            assign op_d[gi]  = op_q[gi-1];
            assign rd_d[gi]  = rd_q[gi-1];
            assign tag_d[gi] = tag_q[gi-1];
        end
    end

    // Slot 0 registers the extended operands so the multiplier sits between two registers.
    if (STAGES == 1) begin : g_single
        assign res_d[0] = mul_sel(opa_d, opb_d, op_i);
    end else begin : g_multi
        logic [XLEN:0] opa_q, opb_q;

        always_ff @(posedge clk_i) begin
            if (!stall_i) begin
                opa_q <= opa_d;
                opb_q <= opb_d;
            end
        end

        assign res_d[0] = '0;
        assign res_d[1] = mul_sel(opa_q, opb_q, op_q[0]);
        for (gi = 2; gi < STAGES; gi++) begin : g_res
            assign res_d[gi] = res_q[gi-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            vld_q <= '0;
        end else if (!stall_i) begin
            vld_q <= vld_d;
        end
        if (!stall_i) begin
            for (int s = 0; s < STAGES; s++) begin
                op_q[s]  <= op_d[s];
                rd_q[s]  <= rd_d[s];
                tag_q[s] <= tag_d[s];
                res_q[s] <= res_d[s];
            end
        end
    end

    assign ready_o  = ~stall_i;
    assign valid_o  = vld_q[LAST];
    assign result_o = vld_q[LAST] ? res_q[LAST] : '0;
    assign rd_o     = vld_q[LAST] ? rd_q[LAST]  : '0;
    assign tag_o    = vld_q[LAST] ? tag_q[LAST] : '0;
    assign busy_o   = |vld_q;

`ifdef MUL_HAZARD_EN
    logic [REGS-1:0] pending_d;

    always_comb begin
        pending_d = '0;
        for (int s = 0; s < STAGES; s++) begin
            if (vld_q[s] && (rd_q[s] != 5'd0)) begin
                pending_d[rd_q[s]] = 1'b1;
            end
        end
    end

    assign pending_o = pending_d;
`endif

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Bench for mul_pipe_unit: three instances (XLEN/STAGES = 32/4, 32/1, 16/6) share stimulus and are
// checked every cycle against a queue-based reference of issued ops. Honours MUL_HAZARD_EN.
module tb_mul_pipe_unit;
    logic        clk = 1'b0;
    logic        rst_in = 1'b1, valid_in = 1'b0, stall_in = 1'b0, flush_in = 1'b0;
    logic [1:0]  op_in = '0;
    logic [31:0] a_in = '0, b_in = '0;
    logic [4:0]  rd_in = '0;
    logic [3:0]  tag_in = '0;

    logic        rdy4, v4, bz4, rdy1, v1, bz1, rdy6, v6, bz6;
    logic [31:0] r4, r1;
    logic [15:0] r6;
    logic [4:0]  rd4, rd1, rd6;
    logic [3:0]  tg4, tg1, tg6;
    logic [31:0] p4, p1, p6;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_pipe_unit #(.XLEN(32), .STAGES(4), .TAG_W(4), .REGS(32)) dut4 (
        .clk_i(clk), .rst_i(rst_in), .valid_i(valid_in), .op_i(op_in), .a_i(a_in), .b_i(b_in),
        .rd_i(rd_in), .tag_i(tag_in), .stall_i(stall_in), .flush_i(flush_in), .ready_o(rdy4),
        .valid_o(v4), .result_o(r4), .rd_o(rd4), .tag_o(tg4), .busy_o(bz4)
`ifdef MUL_HAZARD_EN
        , .pending_o(p4)
`endif
    );

    mul_pipe_unit #(.XLEN(32), .STAGES(1), .TAG_W(4), .REGS(32)) dut1 (
        .clk_i(clk), .rst_i(rst_in), .valid_i(valid_in), .op_i(op_in), .a_i(a_in), .b_i(b_in),
        .rd_i(rd_in), .tag_i(tag_in), .stall_i(stall_in), .flush_i(flush_in), .ready_o(rdy1),
        .valid_o(v1), .result_o(r1), .rd_o(rd1), .tag_o(tg1), .busy_o(bz1)
`ifdef MUL_HAZARD_EN
        , .pending_o(p1)
`endif
    );

    mul_pipe_unit #(.XLEN(16), .STAGES(6), .TAG_W(4), .REGS(32)) dut6 (
        .clk_i(clk), .rst_i(rst_in), .valid_i(valid_in), .op_i(op_in), .a_i(a_in[15:0]),
        .b_i(b_in[15:0]), .rd_i(rd_in), .tag_i(tag_in), .stall_i(stall_in), .flush_i(flush_in),
        .ready_o(rdy6), .valid_o(v6), .result_o(r6), .rd_o(rd6), .tag_o(tg6), .busy_o(bz6)
`ifdef MUL_HAZARD_EN
        , .pending_o(p6)
`endif
    );

`ifndef MUL_HAZARD_EN
    assign p4 = '0;
    assign p1 = '0;
    assign p6 = '0;
`endif

    // Reference: every accepted op remembers the advance count at which it entered; an
    // instance with latency L presents it when the advance count reaches base + L - 1.
    typedef struct {
        int          base;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [4:0]  rd;
        logic [3:0]  tag;
    } op_t;

    op_t q[$];
    int  adv = 0;
    int  n_issue = 0;
    bit  last_rst = 1'b0;

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op, input int xl);
        longint      av, bv;
        logic [63:0] p;
        logic [31:0] m;
        m  = (xl == 32) ? 32'hFFFF_FFFF : ((32'h1 << xl) - 32'h1);
        av = longint'(a & m);
        bv = longint'(b & m);
        if (op != 2'd3 && a[xl-1]) av = av - (longint'(1) << xl);
        if (op <= 2'd1 && b[xl-1]) bv = bv - (longint'(1) << xl);
        p = av * bv;
        return (op == 2'd0) ? (p[31:0] & m) : (32'(p >> xl) & m);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_dut(input string nm, input int lat, input int xl, input logic v,
                             input logic [31:0] r, input logic [4:0] rdo, input logic [3:0] tg,
                             input logic bz, input logic [31:0] pend);
        logic        ev  = 1'b0;
        logic        eb  = 1'b0;
        logic [31:0] er  = '0;
        logic [4:0]  erd = '0;
        logic [3:0]  etg = '0;
        logic [31:0] ep  = '0;
        foreach (q[i]) begin
            if (q[i].base + lat - 1 == adv) begin
                ev  = 1'b1;
                er  = ref_mul(q[i].a, q[i].b, q[i].op, xl);
                erd = q[i].rd;
                etg = q[i].tag;
            end
            if (q[i].base + lat - 1 >= adv) begin
                eb = 1'b1;
                if (q[i].rd != 5'd0) ep[q[i].rd] = 1'b1;
            end
        end
        chk({nm, ".valid_o"}, 32'(v), 32'(ev));
        if (ev || last_rst) chk({nm, ".result_o"}, r, er);
        chk({nm, ".rd_o"}, 32'(rdo), 32'(erd));
        chk({nm, ".tag_o"}, 32'(tg), 32'(etg));
        chk({nm, ".busy_o"}, 32'(bz), 32'(eb));
`ifdef MUL_HAZARD_EN
        chk({nm, ".pending_o"}, pend, ep);
`endif
    endtask

    task automatic model_update();
        last_rst = rst_in;
        if (rst_in || flush_in) begin
            q.delete();
        end else if (!stall_in) begin
            adv++;
            if (valid_in) begin
                q.push_back('{adv, a_in, b_in, op_in, rd_in, tag_in});
                n_issue++;
                $display("issue #%0d op=%0d a=%h b=%h rd=%0d tag=%0d", n_issue, op_in, a_in,
                         b_in, rd_in, tag_in);
            end
            while (q.size() > 0 && q[0].base + 6 - 1 < adv) void'(q.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("ready_o", 32'(rdy4), 32'(!stall_in));
        check_dut("s4", 4, 32, v4, r4, rd4, tg4, bz4, p4);
        check_dut("s1", 1, 32, v1, r1, rd1, tg1, bz1, p1);
        check_dut("s6", 6, 16, v6, 32'(r6), rd6, tg6, bz6, p6);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [3:0] tag);
        valid_in = 1'b1; op_in = op; a_in = a; b_in = b; rd_in = rd; tag_in = tag;
        step();
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
        idle(2);

        // Basic MUL: result appears on the 4-stage unit after 4 edges
        issue(2'd0, 32'd7, 32'd6, 5'd5, 4'd3);
        idle(3);
        chk("basic.valid", 32'(v4), 32'd1);
        chk("basic.result", r4, 32'd42);
        chk("basic.rd", 32'(rd4), 32'd5);
        chk("basic.tag", 32'(tg4), 32'd3);
        idle(1);
        chk("basic.one_cycle", 32'(v4), 32'd0);
        idle(6);

        // Signed modes
        issue(2'd1, 32'hFFFF_FFFF, 32'd2, 5'd1, 4'd1);
        issue(2'd3, 32'hFFFF_FFFF, 32'd2, 5'd2, 4'd2);
        issue(2'd2, 32'hFFFF_FFFF, 32'd2, 5'd3, 4'd3);
        issue(2'd0, 32'hFFFF_FFFF, 32'd2, 5'd4, 4'd4);
        issue(2'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 4'd5);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 4'd6);
        idle(8);

        // Throughput: back-to-back
        for (int i = 0; i < 8; i++) issue(2'd0, 32'(i), 32'(i + 1), 5'(i + 8), 4'(i));
        idle(8);

        // Stall then flush with a simultaneous issue
        for (int i = 0; i < 3; i++) issue(2'd0, 32'(i + 3), 32'd5, 5'(i + 1), 4'(i));
        stall_in = 1'b1;
        idle(2);
        chk("stall.busy", 32'(bz4), 32'd1);
        stall_in = 1'b0;
        flush_in = 1'b1;
        issue(2'd0, 32'd9, 32'd9, 5'd9, 4'd9);
        flush_in = 1'b0;
        chk("flush.busy", 32'(bz4), 32'd0);
        idle(8);

        // Reset mid-pipe
        issue(2'd0, 32'd11, 32'd12, 5'd11, 4'd1);
        issue(2'd3, 32'd13, 32'd14, 5'd12, 4'd2);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("rst.valid", 32'(v4), 32'd0);
        idle(8);

        // Destination tracking: rd 5, rd 9, and rd 0
        issue(2'd0, 32'd2, 32'd3, 5'd5, 4'd1);
        issue(2'd0, 32'd4, 32'd5, 5'd9, 4'd2);
`ifdef MUL_HAZARD_EN
        chk("hazard.pending", p4, 32'h0000_0220);
`endif
        issue(2'd0, 32'd6, 32'd7, 5'd0, 4'd3);
        idle(8);

        // Randomised traffic with stalls, flushes and occasional resets
        for (int i = 0; i < 400; i++) begin
            rst_in   = ($urandom_range(0, 99) == 0);
            flush_in = ($urandom_range(0, 29) == 0);
            stall_in = ($urandom_range(0, 6) == 0);
            valid_in = ($urandom_range(0, 2) != 0);
            op_in    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       a_in = 32'h8000_0000;
                1:       a_in = 32'hFFFF_8000;
                default: a_in = $urandom;
            endcase
            b_in   = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom;
            rd_in  = 5'($urandom_range(0, 31));
            tag_in = 4'($urandom_range(0, 15));
            step();
        end
        rst_in = 1'b0; flush_in = 1'b0; stall_in = 1'b0;
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
